// File: rtl/cpu_bus_master.sv
// Bridges 8/16/32-bit CPU requests onto a 16-bit strobed bus with wait states.
// Long accesses run as two word cycles separated by a mandatory idle gap.
module cpu_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_cs,
    output logic [22:1] bus_address,
    output logic        bus_uds,
    output logic        bus_lds,
    output logic        bus_write_strobe,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    input  logic        bus_ack,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready is 1 only in IDLE, and request fields
    // are sampled only on that edge.

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic [22:1]   addr_q, addr_d;
    logic          lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [15:0]   wdata_lo_q, wdata_lo_d;
    logic          second_q, second_d;
    logic [15:0]   rbuf_q, rbuf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          bus_cs_q, bus_cs_d;
    logic          bus_uds_q, bus_uds_d;
    logic          bus_lds_q, bus_lds_d;
    logic          bus_we_q, bus_we_d;
    logic [22:1]   bus_addr_q, bus_addr_d;
    logic [15:0]   bus_dout_q, bus_dout_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        size_d       = size_q;
        write_d      = write_q;
        wdata_lo_d   = wdata_lo_q;
        second_d     = second_q;
        rbuf_d       = rbuf_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + CW'(1);
        bus_cs_d     = bus_cs_q;
        bus_uds_d    = bus_uds_q;
        bus_lds_d    = bus_lds_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_dout_d   = bus_dout_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_size == SZ_RSVD || (req_size != SZ_BYTE && req_addr[0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d    = ST_ACCESS;
                        addr_d     = req_addr[22:1];
                        lane_d     = req_addr[0];
                        size_d     = req_size;
                        write_d    = req_write;
                        wdata_lo_d = req_wdata[15:0];
                        second_d   = 1'b0;
                        cnt_d      = '0;
                        bus_cs_d   = 1'b1;
                        bus_we_d   = req_write;
                        bus_addr_d = req_addr[22:1];
                        // Even byte addresses live on the upper lane.
                        bus_uds_d  = (req_size != SZ_BYTE) || !req_addr[0];
                        bus_lds_d  = (req_size != SZ_BYTE) || req_addr[0];
                        case (req_size)
                            SZ_BYTE: bus_dout_d = {2{req_wdata[7:0]}};
                            SZ_WORD: bus_dout_d = req_wdata[15:0];
                            default: bus_dout_d = req_wdata[31:16];
                        endcase
                    end
                end
            end

            ST_ACCESS: begin
                if (bus_ack) begin
                    state_d   = ST_CAPTURE;
                    bus_cs_d  = 1'b0;
                    bus_uds_d = 1'b0;
                    bus_lds_d = 1'b0;
                    bus_we_d  = 1'b0;
                end else if (cnt_inc == TO_LIMIT) begin
                    // Abort: any pending second long half is dropped.
                    state_d      = ST_RESP;
                    cnt_d        = cnt_inc;
                    bus_cs_d     = 1'b0;
                    bus_uds_d    = 1'b0;
                    bus_lds_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'hFFFF_FFFF;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_CAPTURE: begin
                if (size_q == SZ_LONG && !second_q) begin
                    state_d    = ST_ACCESS;
                    rbuf_d     = bus_din;
                    second_d   = 1'b1;
                    cnt_d      = '0;
                    bus_cs_d   = 1'b1;
                    bus_uds_d  = 1'b1;
                    bus_lds_d  = 1'b1;
                    bus_we_d   = write_q;
                    bus_addr_d = addr_q + 22'd1;
                    bus_dout_d = wdata_lo_q;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    if (write_q) begin
                        resp_rdata_d = 32'h0;
                    end else begin
                        case (size_q)
                            SZ_BYTE: resp_rdata_d = {24'h0, lane_q ? bus_din[7:0] : bus_din[15:8]};
                            SZ_WORD: resp_rdata_d = {16'h0, bus_din};
                            default: resp_rdata_d = {rbuf_q, bus_din};
                        endcase
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            addr_q       <= '0;
            lane_q       <= 1'b0;
            size_q       <= SZ_BYTE;
            write_q      <= 1'b0;
            wdata_lo_q   <= '0;
            second_q     <= 1'b0;
            rbuf_q       <= '0;
            cnt_q        <= '0;
            bus_cs_q     <= 1'b0;
            bus_uds_q    <= 1'b0;
            bus_lds_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_dout_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            write_q      <= write_d;
            wdata_lo_q   <= wdata_lo_d;
            second_q     <= second_d;
            rbuf_q       <= rbuf_d;
            cnt_q        <= cnt_d;
            bus_cs_q     <= bus_cs_d;
            bus_uds_q    <= bus_uds_d;
            bus_lds_q    <= bus_lds_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_dout_q   <= bus_dout_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_err         = resp_err_q;
    assign bus_cs           = bus_cs_q;
    assign bus_address      = bus_addr_q;
    assign bus_uds          = bus_uds_q;
    assign bus_lds          = bus_lds_q;
    assign bus_write_strobe = bus_we_q;
    assign bus_dout         = bus_dout_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: transaction-level model of bus cycles and responses,
// a responder with programmable wait states, directed corner cases plus random traffic.
module tb_cpu_bus_master;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [22:0] req_addr;
    logic [1:0]  req_size;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_cs;
    logic [21:0] bus_address;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_write_strobe;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_ack;
    logic [1:0]  dbg_state;

    cpu_bus_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_write        (req_write),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .bus_cs           (bus_cs),
        .bus_address      (bus_address),
        .bus_uds          (bus_uds),
        .bus_lds          (bus_lds),
        .bus_write_strobe (bus_write_strobe),
        .bus_dout         (bus_dout),
        .bus_din          (bus_din),
        .bus_ack          (bus_ack),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];          // {err, rdata} per expected response
    logic [21:0] exp_addr[2];
    logic        exp_uds[2];
    logic        exp_lds[2];
    logic [15:0] exp_dout[2];
    int          exp_n;
    int          exp_lat;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Transaction-level reference: which bus cycles occur, the response and its latency.
    task automatic model(input logic [22:0] a, input logic [1:0] sz, input logic wr,
                         input logic [31:0] wd, input int w0, input int w1,
                         input logic [15:0] d0, input logic [15:0] d1);
        int          waits[2];
        int          halves;
        bit          timed;
        logic [31:0] rd;
        waits[0] = w0;
        waits[1] = w1;
        exp_n    = 0;
        exp_lat  = 0;
        timed    = 0;
        if (sz == 2'b11 || (sz != 2'b00 && a[0])) begin
            exp_lat = 1;
            exp_q.push_back({1'b1, 32'h0});
            return;
        end
        halves = (sz == 2'b10) ? 2 : 1;
        for (int h = 0; h < halves; h++) begin
            exp_addr[h] = a[22:1] + 22'(h);
            if (sz == 2'b00) begin
                exp_uds[h]  = !a[0];
                exp_lds[h]  = a[0];
                exp_dout[h] = {wd[7:0], wd[7:0]};
            end else begin
                exp_uds[h]  = 1'b1;
                exp_lds[h]  = 1'b1;
                exp_dout[h] = (sz == 2'b01 || h == 1) ? wd[15:0] : wd[31:16];
            end
            exp_n++;
            if (waits[h] >= TIMEOUT) begin
                exp_lat += TIMEOUT + 1;
                timed = 1;
                break;
            end
            exp_lat += waits[h] + 2;
        end
        if (timed) begin
            exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        end else begin
            exp_lat += 1;
            if (wr) rd = 32'h0;
            else if (sz == 2'b00) rd = {24'h0, a[0] ? d0[7:0] : d0[15:8]};
            else if (sz == 2'b01) rd = {16'h0, d0};
            else rd = {d0, d1};
            exp_q.push_back({1'b0, rd});
        end
    endtask

    // ---------------- driver + responder ----------------
    // Called and returns at a falling edge.
    task automatic run_txn(input logic [22:0] a, input logic [1:0] sz, input logic wr,
                           input logic [31:0] wd, input int w0, input int w1,
                           input logic [15:0] d0, input logic [15:0] d1);
        int          waits[2];
        logic [15:0] dins[2];
        int          n;
        int          cur;
        int          acc_len;
        int          wait_left;
        bit          in_cyc;
        bit          ack_given;
        bit          got;
        logic [32:0] exp_r;
        waits[0] = w0;
        waits[1] = w1;
        dins[0]  = d0;
        dins[1]  = d1;
        exp_r    = '0;
        model(a, sz, wr, wd, w0, w1, d0, d1);

        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = sz;
        req_write = wr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 23'($urandom);
        req_size  = 2'($urandom);
        req_write = 1'($urandom);
        req_wdata = $urandom;

        n = 0; cur = 0; acc_len = 0; wait_left = 0;
        in_cyc = 0; ack_given = 0; got = 0;
        while (!got && n < 700) begin
            @(negedge clk);
            n++;
            if (ack_given) begin
                chk("gap_strobes", {bus_cs, bus_uds, bus_lds, bus_write_strobe}, 4'b0000);
                bus_din   = (cur >= 1 && cur <= 2) ? dins[cur-1] : 16'h0;
                ack_given = 0;
                bus_ack   = 1'b0;
            end else if (bus_cs) begin
                if (!in_cyc) begin
                    in_cyc    = 1;
                    cur++;
                    acc_len   = 0;
                    wait_left = (cur <= 2) ? waits[cur-1] : 0;
                end
                acc_len++;
                if (cur <= exp_n) begin
                    chk("bus_ctl", {bus_address, bus_uds, bus_lds, bus_write_strobe},
                        {exp_addr[cur-1], exp_uds[cur-1], exp_lds[cur-1], wr});
                    if (wr) chk("bus_dout", bus_dout, exp_dout[cur-1]);
                end
                bus_din = 16'($urandom);
                if (wait_left == 0) begin
                    bus_ack   = 1'b1;
                    ack_given = 1;
                    in_cyc    = 0;
                end else begin
                    bus_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                if (in_cyc) begin
                    chk("timeout_len", acc_len, TIMEOUT);
                    in_cyc = 0;
                end
                bus_ack = 1'b0;
            end
            if (resp_valid) begin
                got = 1;
                chk("latency", n, exp_lat);
                if (exp_q.size() > 0) exp_r = exp_q.pop_front();
                chk("resp_err", resp_err, exp_r[32]);
                chk("resp_rdata", resp_rdata, exp_r[31:0]);
                chk("ready_in_resp", req_ready, 0);
            end
        end
        bus_ack = 1'b0;
        if (!got) begin
            chk("resp_seen", 0, 1);
            exp_q.delete();
        end else begin
            @(negedge clk);
            chk("resp_one_cycle", resp_valid, 0);
            chk("ready_after_resp", req_ready, 1);
            chk("rdata_held", resp_rdata, exp_r[31:0]);
            chk("err_held", resp_err, exp_r[32]);
        end
        chk("bus_cycles", cur, exp_n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [22:0] ra;
        logic [1:0]  rs;
        int          r;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        bus_din   = '0;
        bus_ack   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_strobes", {bus_cs, bus_uds, bus_lds, bus_write_strobe}, 4'b0000);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_address", bus_address, 0);
        chk("rst_dout", bus_dout, 0);
        reset = 1'b0;
        @(negedge clk);

        // Word read with one wait state.
        run_txn(23'h000100, 2'b01, 1'b0, 32'hDEAD_BEEF, 1, 0, 16'h5AA5, 16'h0);
        // Odd byte write: lower lane only, data replicated.
        run_txn(23'h4FFFF1, 2'b00, 1'b1, 32'h1234_563C, 0, 0, 16'h0, 16'h0);
        // Even byte read: upper lane.
        run_txn(23'h000222, 2'b00, 1'b0, 32'h0, 2, 0, 16'hC381, 16'h0);
        // Long read across the top of the address space.
        run_txn(23'h7FFFFE, 2'b10, 1'b0, 32'h0, 0, 0, 16'h1234, 16'hABCD);
        // Long write with waits on both halves.
        run_txn(23'h012344, 2'b10, 1'b1, 32'hCAFE_F00D, 2, 3, 16'h0, 16'h0);
        // Misaligned word write and reserved size: no bus cycle.
        run_txn(23'h000003, 2'b01, 1'b1, 32'h0000_7777, 0, 0, 16'h0, 16'h0);
        run_txn(23'h000010, 2'b11, 1'b0, 32'h0, 0, 0, 16'h0, 16'h0);
        // Timeout on a word read, ack on the last allowed cycle, timeout on a long second half.
        run_txn(23'h000400, 2'b01, 1'b0, 32'h0, 1000, 0, 16'h1111, 16'h0);
        run_txn(23'h000402, 2'b01, 1'b0, 32'h0, TIMEOUT - 1, 0, 16'h2222, 16'h0);
        run_txn(23'h000404, 2'b10, 1'b0, 32'h0, 0, 1000, 16'h3333, 16'h4444);

        for (int i = 0; i < 40; i++) begin
            ra = 23'($urandom);
            if ($urandom_range(0, 3) == 0) ra = {22'h3FFFFF, 1'($urandom)};
            r = $urandom_range(0, 9);
            rs = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            run_txn(ra, rs, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    16'($urandom), 16'($urandom));
        end

        // Reset in the middle of a long write, then a normal request.
        req_valid = 1'b1;
        req_addr  = 23'h002000;
        req_size  = 2'b10;
        req_write = 1'b1;
        req_wdata = 32'h8765_4321;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_access_cs", bus_cs, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {bus_cs, bus_uds, bus_lds, bus_write_strobe}, 4'b0000);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_address", bus_address, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_resp_after_abort", {resp_valid, bus_cs}, 2'b00);
        end
        run_txn(23'h000100, 2'b01, 1'b0, 32'h0, 0, 0, 16'h6789, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
